// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory request, a one-entry
// presentation buffer toward decode, and redirect handling with in-flight cancel.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_adel
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        cancel_q, cancel_d;
  logic        ifValid_q, ifValid_d;
  logic [31:0] ifPc_q, ifPc_d;
  logic [31:0] ifInst_q, ifInst_d;
  logic        ifAdel_q, ifAdel_d;

  logic pcAligned;
  assign pcAligned = (pc_q[1:0] == 2'b00);

  // A misaligned pc never reaches memory; it is turned into a faulting entry instead.
  assign inst_req  = !rst && (state_q == REQ) && pcAligned;
  assign inst_addr = pc_q;
  assign pc        = pc_q;
  assign if_valid  = ifValid_q;
  assign if_pc     = ifPc_q;
  assign if_inst   = ifInst_q;
  assign if_adel   = ifAdel_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cancel_d  = cancel_q;
    ifValid_d = ifValid_q;
    ifPc_d    = ifPc_q;
    ifInst_d  = ifInst_q;
    ifAdel_d  = ifAdel_q;
    case (state_q)
      REQ: begin
        if (!pcAligned) begin
          if (redirect_valid) begin
            pc_d = redirect_pc;
          end else begin
            state_d   = HOLD;
            ifValid_d = 1'b1;
            ifAdel_d  = 1'b1;
            ifInst_d  = 32'h0;
            ifPc_d    = pc_q;
          end
        end else begin
          // A redirect in the accept cycle leaves a response in flight that must be dropped.
          if (inst_addr_ok) begin
            state_d  = WAIT;
            cancel_d = redirect_valid;
          end
          if (redirect_valid) pc_d = redirect_pc;
        end
      end
      WAIT: begin
        if (inst_data_ok) begin
          if (cancel_q || redirect_valid) begin
            state_d  = REQ;
            cancel_d = 1'b0;
            if (redirect_valid) pc_d = redirect_pc;
          end else begin
            state_d   = HOLD;
            ifValid_d = 1'b1;
            ifPc_d    = pc_q;
            ifInst_d  = inst_rdata;
            ifAdel_d  = 1'b0;
          end
        end else if (redirect_valid) begin
          cancel_d = 1'b1;
          pc_d     = redirect_pc;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          state_d   = REQ;
          ifValid_d = 1'b0;
          pc_d      = redirect_pc;
        end else if (!stall) begin
          state_d   = REQ;
          ifValid_d = 1'b0;
          pc_d      = pc_q + 32'd4;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      cancel_q  <= 1'b0;
      ifValid_q <= 1'b0;
      ifPc_q    <= 32'h0;
      ifInst_q  <= 32'h0;
      ifAdel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cancel_q  <= cancel_d;
      ifValid_q <= ifValid_d;
      ifPc_q    <= ifPc_d;
      ifInst_q  <= ifInst_d;
      ifAdel_q  <= ifAdel_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic, with a
// transaction-level reference model and a randomised memory responder.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .pc(pc), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model: fetch address, whether a request is in flight (and doomed),
  // and the entry currently offered to decode.
  logic [31:0] mPc, mIfPc, mIfInst;
  bit          mInFlight, mDoomed, mHasEntry, mAdel;

  // Memory responder knobs and its own view of the outstanding transaction.
  int          acceptPct = 100, delayMin = 2, delayMax = 2, spuriousPct = 0;
  bit          useFixed = 1'b0;
  logic [31:0] fixedData = 32'h0;
  bit          memPending = 1'b0;
  int          memCnt = 0;

  task automatic check1(input string tag, input logic obs, input logic exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    mPc = RESET_PC; mInFlight = 0; mDoomed = 0; mHasEntry = 0;
    mAdel = 0; mIfPc = 32'h0; mIfInst = 32'h0;
  endfunction

  function automatic bit modelReq();
    return !rst && !mInFlight && !mHasEntry && (mPc[1:0] == 2'b00);
  endfunction

  // One clock of the fetch rules, applied to the inputs held across the edge.
  function automatic void modelStep();
    if (rst) begin
      modelReset();
    end else if (mHasEntry) begin
      if (redirect_valid) begin mHasEntry = 0; mPc = redirect_pc; end
      else if (!stall) begin mHasEntry = 0; mPc = mPc + 32'd4; end
    end else if (mInFlight) begin
      if (inst_data_ok) begin
        mInFlight = 0;
        if (mDoomed || redirect_valid) begin
          mDoomed = 0;
          if (redirect_valid) mPc = redirect_pc;
        end else begin
          mHasEntry = 1; mAdel = 0; mIfPc = mPc; mIfInst = inst_rdata;
        end
      end else if (redirect_valid) begin
        mDoomed = 1; mPc = redirect_pc;
      end
    end else if (mPc[1:0] != 2'b00) begin
      if (redirect_valid) mPc = redirect_pc;
      else begin mHasEntry = 1; mAdel = 1; mIfPc = mPc; mIfInst = 32'h0; end
    end else begin
      if (inst_addr_ok) begin mInFlight = 1; mDoomed = redirect_valid; end
      if (redirect_valid) mPc = redirect_pc;
    end
  endfunction

  task automatic checkOutput();
    check1("inst_req", inst_req, modelReq());
    check32("inst_addr", inst_addr, mPc);
    check32("pc", pc, mPc);
    check1("if_valid", if_valid, mHasEntry);
    if (mHasEntry) begin
      check32("if_pc", if_pc, mIfPc);
      check32("if_inst", if_inst, mIfInst);
      check1("if_adel", if_adel, mAdel);
    end
  endtask

  // Memory side: at most one transaction, response 1+ cycles after acceptance.
  task automatic memRespond();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = $urandom;
    if (memPending) begin
      memCnt--;
      if (memCnt == 0) begin
        inst_data_ok = 1'b1;
        inst_rdata   = useFixed ? fixedData : $urandom;
        memPending   = 1'b0;
      end
    end else if (int'($urandom_range(99)) < spuriousPct) begin
      inst_data_ok = 1'b1;
    end
    if (!memPending && inst_req && int'($urandom_range(99)) < acceptPct) begin
      inst_addr_ok = 1'b1;
      memPending   = 1'b1;
      memCnt       = int'($urandom_range(delayMax, delayMin));
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    memRespond();
  endtask

  task automatic doReset(input int cycles);
    redirect_valid = 1'b0;
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput();
    check1("rst_inst_req", inst_req, 1'b0);
    repeat (cycles) applyStimulus();
    rst = 1'b0;
    #1 checkOutput();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] savedPc, savedIfPc, savedIfInst;
    int guard;

    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
    modelReset();
    #1;
    check1("reset_inst_req", inst_req, 1'b0);
    check32("reset_pc", pc, RESET_PC);
    check1("reset_if_valid", if_valid, 1'b0);
    check1("reset_if_adel", if_adel, 1'b0);
    check32("reset_if_pc", if_pc, 32'h0);
    check32("reset_if_inst", if_inst, 32'h0);
    repeat (2) applyStimulus();

    $display("[TB] first fetch after reset");
    acceptPct = 100; delayMin = 2; delayMax = 2; useFixed = 1; fixedData = 32'h2400_0001;
    rst = 1'b0;
    #1;
    check1("first_req", inst_req, 1'b1);
    check32("first_addr", inst_addr, 32'hBFC0_0000);
    guard = 0;
    do begin applyStimulus(); guard++; end while (!if_valid && guard < 20);
    check1("first_present", if_valid, 1'b1);
    check32("first_if_pc", if_pc, 32'hBFC0_0000);
    check32("first_if_inst", if_inst, 32'h2400_0001);
    applyStimulus();
    check1("first_drop", if_valid, 1'b0);
    check1("second_req", inst_req, 1'b1);
    check32("second_addr", inst_addr, 32'hBFC0_0004);

    $display("[TB] stall holds the entry");
    stall = 1'b1;
    guard = 0;
    do begin applyStimulus(); guard++; end while (!if_valid && guard < 20);
    check1("stall_present", if_valid, 1'b1);
    savedPc = pc; savedIfPc = if_pc; savedIfInst = if_inst;
    repeat (5) begin
      applyStimulus();
      check1("stall_no_req", inst_req, 1'b0);
      check32("stall_pc", pc, savedPc);
      check32("stall_if_pc", if_pc, savedIfPc);
      check32("stall_if_inst", if_inst, savedIfInst);
    end
    stall = 1'b0;
    applyStimulus();
    check32("stall_release_pc", pc, savedPc + 32'd4);

    $display("[TB] redirect while waiting");
    delayMin = 4; delayMax = 4; fixedData = 32'hDEAD_BEEF;
    guard = 0;
    do begin applyStimulus(); guard++; end while (!(mInFlight && !inst_req) && guard < 20);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    applyStimulus();
    redirect_valid = 1'b0;
    acceptPct = 0;
    guard = 0;
    do begin
      applyStimulus();
      check1("cancel_no_present", if_valid, 1'b0);
      guard++;
    end while (!inst_req && guard < 20);
    check1("cancel_req", inst_req, 1'b1);
    check32("cancel_addr", inst_addr, 32'h8000_0100);

    $display("[TB] misaligned redirect");
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    applyStimulus();
    redirect_valid = 1'b0;
    check1("adel_no_req", inst_req, 1'b0);
    applyStimulus();
    check1("adel_no_req2", inst_req, 1'b0);
    check1("adel_valid", if_valid, 1'b1);
    check1("adel_flag", if_adel, 1'b1);
    check32("adel_if_pc", if_pc, 32'h8000_0102);
    check32("adel_if_inst", if_inst, 32'h0);

    $display("[TB] pc wraparound");
    acceptPct = 100; delayMin = 1; delayMax = 1; useFixed = 0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    applyStimulus();
    redirect_valid = 1'b0;
    check32("wrap_addr_top", inst_addr, 32'hFFFF_FFFC);
    guard = 0;
    do begin applyStimulus(); guard++; end while (!if_valid && guard < 20);
    check32("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    applyStimulus();
    check1("wrap_req", inst_req, 1'b1);
    check32("wrap_addr", inst_addr, 32'h0000_0000);

    $display("[TB] reset during outstanding fetch");
    delayMin = 5; delayMax = 5;
    guard = 0;
    do begin applyStimulus(); guard++; end while (!(mInFlight && !inst_req) && guard < 20);
    doReset(2);
    check1("rst_release_req", inst_req, 1'b1);
    check32("rst_release_addr", inst_addr, RESET_PC);
    guard = 0;
    do begin applyStimulus(); guard++; end while (!if_valid && guard < 30);
    check1("rst_fresh_present", if_valid, 1'b1);
    check32("rst_fresh_if_pc", if_pc, RESET_PC);

    $display("[TB] random traffic");
    acceptPct = 70; delayMin = 1; delayMax = 3; spuriousPct = 10;
    for (int i = 0; i < 4000; i++) begin
      int r;
      stall = (int'($urandom_range(99)) < 50);
      redirect_valid = (int'($urandom_range(99)) < 6);
      r = int'($urandom_range(9));
      redirect_pc = $urandom & 32'hFFFF_FFFC;
      if (r == 0) redirect_pc = 32'hFFFF_FFFC;
      else if (r == 1) redirect_pc = redirect_pc | 32'h2;
      if (int'($urandom_range(999)) < 3) doReset(int'($urandom_range(3, 1)));
      else applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
